// File: rtl/vga_defs_pkg.sv
// Shared VGA frame-buffer definitions.
// Holds the default frame geometry, the bit-width helper used for the
// coordinate and address ports, and the buffer-control FSM state type.
package vga_defs;

  localparam int DEF_WIDTH      = 640;
  localparam int DEF_HEIGHT     = 480;
  localparam int DEF_PIXEL_SIZE = 3;

  // Number of bits needed to hold every value 0..n (minimum 1).
  // A coordinate port sized this way can also carry the value n itself,
  // so an out-of-range coordinate such as x == WIDTH is representable and
  // can be rejected instead of silently wrapping onto a valid pixel.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) <= n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PEND  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/dbl_frame_buffer_bank.sv
// fb_bank: one pixel bank of the double frame buffer.
// Ports:
//   clk_i     - clock (rising edge)
//   resetn_i  - synchronous active-low reset (read register only)
//   we_i      - write strobe; waddr_i / wdata_i written on the same edge
//   re_i      - read strobe; mem[raddr_i] captured into rdata_o
//   rdata_o   - registered read data, holds while re_i is low
// The pixel array itself is never reset.
module fb_bank #(
  parameter int DEPTH      = 12,
  parameter int AW         = 4,
  parameter int PIXEL_SIZE = 3
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [PIXEL_SIZE-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [PIXEL_SIZE-1:0] rdata_o
);

  logic [PIXEL_SIZE-1:0] mem_q [DEPTH];
  logic [PIXEL_SIZE-1:0] rdata_q;

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbl_frame_buffer.sv
// dbl_frame_buffer: two-bank VGA frame buffer with frame-synchronous swap.
// The drawing side writes the back bank (!front_sel), the scan-out side
// reads the front bank. A swap request is held until the next frame_end;
// a clear request fills the back bank with one colour, one pixel per cycle.
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   wr_en, wr_x, wr_y, wr_data  - back-bank pixel write
//   rd_en, rd_x, rd_y, rd_data  - front-bank pixel read, latency 1
//   frame_end                   - start of vertical blank pulse
//   swap_req / swap_pending / swap_ack - buffer exchange handshake
//   clear_req / clear_color / busy     - back-bank fill
//   front_sel                   - bank currently displayed
module dbl_frame_buffer
  import vga_defs::*;
#(
  parameter int  WIDTH      = DEF_WIDTH,
  parameter int  HEIGHT     = DEF_HEIGHT,
  parameter int  PIXEL_SIZE = DEF_PIXEL_SIZE,
  localparam int XW         = clog2(WIDTH),
  localparam int YW         = clog2(HEIGHT),
  localparam int DEPTH      = WIDTH * HEIGHT,
  localparam int AW         = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [XW-1:0]         wr_x,
  input  logic [YW-1:0]         wr_y,
  input  logic [PIXEL_SIZE-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [XW-1:0]         rd_x,
  input  logic [YW-1:0]         rd_y,
  output logic [PIXEL_SIZE-1:0] rd_data,
  input  logic                  frame_end,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_ack,
  input  logic                  clear_req,
  input  logic [PIXEL_SIZE-1:0] clear_color,
  output logic                  busy,
  output logic                  front_sel
);

  fb_state_e             state_q;
  logic                  front_sel_q, swap_pending_q, swap_ack_q, busy_q, deferred_q;
  logic [AW-1:0]         clr_cnt_q;
  logic [PIXEL_SIZE-1:0] clr_color_q;
  logic                  rd_sel_q, rd_oob_q;

  logic                  wr_in_range_s, rd_in_range_s;
  logic [AW-1:0]         wr_addr_s, rd_addr_s, bank_waddr_s;
  logic [PIXEL_SIZE-1:0] bank_wdata_s;
  logic [1:0]            bank_we_s;
  logic                  bank_re_s;
  logic [PIXEL_SIZE-1:0] bank0_rdata_s, bank1_rdata_s;

  // Linear addresses and range checks for both coordinate pairs.
  always_comb begin
    wr_in_range_s = (wr_x < XW'(WIDTH)) && (wr_y < YW'(HEIGHT));
    rd_in_range_s = (rd_x < XW'(WIDTH)) && (rd_y < YW'(HEIGHT));
    wr_addr_s     = AW'(32'(wr_y) * 32'(WIDTH) + 32'(wr_x));
    rd_addr_s     = AW'(32'(rd_y) * 32'(WIDTH) + 32'(rd_x));
    bank_re_s     = rd_en && rd_in_range_s;
  end

  // Back-bank write mux: the clear engine owns the port while clearing,
  // otherwise the drawing side writes in-range pixels.
  always_comb begin
    bank_we_s    = 2'b00;
    bank_waddr_s = wr_addr_s;
    bank_wdata_s = wr_data;
    if (state_q == ST_CLEAR) begin
      bank_waddr_s            = clr_cnt_q;
      bank_wdata_s            = clr_color_q;
      bank_we_s[~front_sel_q] = 1'b1;
    end else if (wr_en && wr_in_range_s) begin
      bank_we_s[~front_sel_q] = 1'b1;
    end else begin
      bank_we_s = 2'b00;
    end
  end

  fb_bank #(.DEPTH(DEPTH), .AW(AW), .PIXEL_SIZE(PIXEL_SIZE)) u_bank0 (
    .clk_i(clk), .resetn_i(resetn), .we_i(bank_we_s[0]), .waddr_i(bank_waddr_s),
    .wdata_i(bank_wdata_s), .re_i(bank_re_s), .raddr_i(rd_addr_s), .rdata_o(bank0_rdata_s)
  );

  fb_bank #(.DEPTH(DEPTH), .AW(AW), .PIXEL_SIZE(PIXEL_SIZE)) u_bank1 (
    .clk_i(clk), .resetn_i(resetn), .we_i(bank_we_s[1]), .waddr_i(bank_waddr_s),
    .wdata_i(bank_wdata_s), .re_i(bank_re_s), .raddr_i(rd_addr_s), .rdata_o(bank1_rdata_s)
  );

  // Read-side bookkeeping: remember which bank and whether the coordinate
  // was valid at the time of the read, so a later swap cannot change held data.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_sel_q <= 1'b0;
      rd_oob_q <= 1'b0;
    end else if (rd_en) begin
      rd_sel_q <= front_sel_q;
      rd_oob_q <= !rd_in_range_s;
    end
  end

  // Selection among registered values only; no input reaches rd_data
  // without passing through a flop.
  assign rd_data = rd_oob_q ? '0 : (rd_sel_q ? bank1_rdata_s : bank0_rdata_s);

  // Buffer-control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
      busy_q         <= 1'b0;
      deferred_q     <= 1'b0;
      clr_cnt_q      <= '0;
      clr_color_q    <= '0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            // Clear wins; a simultaneous swap is deferred until the fill ends.
            state_q        <= ST_CLEAR;
            clr_cnt_q      <= '0;
            clr_color_q    <= clear_color;
            deferred_q     <= swap_req;
            swap_pending_q <= swap_req;
            busy_q         <= 1'b1;
          end else if (swap_req && frame_end) begin
            front_sel_q <= ~front_sel_q;
            swap_ack_q  <= 1'b1;
          end else if (swap_req) begin
            state_q        <= ST_PEND;
            swap_pending_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q        <= (deferred_q || swap_req) ? ST_PEND : ST_IDLE;
            swap_pending_q <= deferred_q || swap_req;
            deferred_q     <= 1'b0;
            busy_q         <= 1'b0;
            clr_cnt_q      <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
            if (swap_req) begin
              deferred_q     <= 1'b1;
              swap_pending_q <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (frame_end) begin
            front_sel_q    <= ~front_sel_q;
            swap_ack_q     <= 1'b1;
            swap_pending_q <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q        <= ST_IDLE;
          swap_pending_q <= 1'b0;
          busy_q         <= 1'b0;
          deferred_q     <= 1'b0;
        end
      endcase
    end
  end

  assign front_sel    = front_sel_q;
  assign swap_pending = swap_pending_q;
  assign swap_ack     = swap_ack_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dbl_frame_buffer.sv
// Directed-plus-random bench for dbl_frame_buffer at 4x3 pixels, 3 bpp.
// A reference model (two pixel arrays plus the displayed-bank index) is
// updated from the behavioural rules and every read is compared against it.
module tb_dbl_frame_buffer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_en, rd_en, frame_end, swap_req, clear_req;
  logic [2:0] wr_x, rd_x;
  logic [1:0] wr_y, rd_y;
  logic [2:0] wr_data, rd_data, clear_color;
  logic       swap_pending, swap_ack, busy, front_sel;

  int total = 0;
  int bad   = 0;

  // Reference model: pixel contents per bank and which bank is displayed.
  int mem_m [2][N];
  int front_m;

  dbl_frame_buffer #(.WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(3)) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .frame_end(frame_end), .swap_req(swap_req), .swap_pending(swap_pending),
    .swap_ack(swap_ack), .clear_req(clear_req), .clear_color(clear_color),
    .busy(busy), .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_pixel(input int x, input int y);
    if (x >= W || y >= H) return 0;
    return mem_m[front_m][y * W + x];
  endfunction

  task automatic wr_px(input int x, input int y, input int d);
    wr_en = 1'b1; wr_x = 3'(x); wr_y = 2'(y); wr_data = 3'(d);
    cyc();
    wr_en = 1'b0;
    if (x < W && y < H) mem_m[1 - front_m][y * W + x] = d;
  endtask

  task automatic rd_chk(input string tag, input int x, input int y);
    rd_en = 1'b1; rd_x = 3'(x); rd_y = 2'(y);
    cyc();
    rd_en = 1'b0;
    chk(tag, 32'(rd_data), 32'(exp_pixel(x, y)));
  endtask

  task automatic swap_now(input string tag);
    swap_req = 1'b1; frame_end = 1'b1;
    cyc();
    swap_req = 1'b0; frame_end = 1'b0;
    front_m = 1 - front_m;
    chk({tag, "_front"}, 32'(front_sel), 32'(front_m));
    chk({tag, "_ack"}, 32'(swap_ack), 32'd1);
    chk({tag, "_pend"}, 32'(swap_pending), 32'd0);
  endtask

  initial begin
    int n, acks, d;
    resetn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; frame_end = 1'b0;
    swap_req = 1'b0; clear_req = 1'b0;
    wr_x = 3'd0; wr_y = 2'd0; wr_data = 3'd0; rd_x = 3'd0; rd_y = 2'd0;
    clear_color = 3'd0;
    front_m = 0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < N; i++) mem_m[b][i] = 0;

    // Reset state
    cyc(); cyc();
    chk("rst_front", 32'(front_sel), 32'd0);
    chk("rst_pend", 32'(swap_pending), 32'd0);
    chk("rst_ack", 32'(swap_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    resetn = 1'b1;
    cyc();

    // Basic write, pending swap, frame-end swap, read back
    wr_px(1, 2, 5);
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    chk("pend_set", 32'(swap_pending), 32'd1);
    chk("pend_front", 32'(front_sel), 32'd0);
    cyc();
    chk("pend_hold", 32'(swap_pending), 32'd1);
    frame_end = 1'b1; cyc(); frame_end = 1'b0;
    front_m = 1 - front_m;
    chk("swap_front", 32'(front_sel), 32'(front_m));
    chk("swap_ack", 32'(swap_ack), 32'd1);
    chk("swap_pend_clr", 32'(swap_pending), 32'd0);
    cyc();
    chk("swap_ack_pulse", 32'(swap_ack), 32'd0);
    rd_chk("rd_1_2", 1, 2);
    cyc();
    chk("rd_hold", 32'(rd_data), 32'd5);

    // Random fill of the back bank, immediate swap, random read/write overlap
    for (int i = 0; i < N; i++) wr_px(i % W, i / W, $urandom_range(0, 7));
    swap_now("imm_swap");
    for (int i = 0; i < N; i++) begin
      // Same coordinate read from front and written to back in one cycle.
      d = $urandom_range(0, 7);
      rd_en = 1'b1; rd_x = 3'(i % W); rd_y = 2'(i / W);
      wr_en = 1'b1; wr_x = 3'(i % W); wr_y = 2'(i / W); wr_data = 3'(d);
      cyc();
      rd_en = 1'b0; wr_en = 1'b0;
      chk("rd_overlap", 32'(rd_data), 32'(mem_m[front_m][i]));
      mem_m[1 - front_m][i] = d;
    end

    // Clear with deferred swap, dropped writes and an ignored second clear
    clear_color = 3'd7; clear_req = 1'b1;
    cyc();
    clear_req = 1'b0; clear_color = 3'd0;
    chk("clr_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      wr_en = 1'b1; wr_x = 3'($urandom_range(0, W - 1)); wr_y = 2'($urandom_range(0, H - 1));
      wr_data = 3'($urandom_range(0, 6));
      swap_req = (n == 3);
      clear_req = (n == 5); clear_color = 3'd2;
      cyc();
      swap_req = 1'b0; clear_req = 1'b0;
    end
    wr_en = 1'b0;
    for (int i = 0; i < N; i++) mem_m[1 - front_m][i] = 7;
    chk("clr_cycles", 32'(n), 32'd12);
    chk("clr_pend_after", 32'(swap_pending), 32'd1);
    chk("clr_front_kept", 32'(front_sel), 32'(front_m));
    frame_end = 1'b1; cyc(); frame_end = 1'b0;
    front_m = 1 - front_m;
    chk("clr_swap_front", 32'(front_sel), 32'(front_m));
    chk("clr_swap_ack", 32'(swap_ack), 32'd1);
    for (int i = 0; i < N; i++) rd_chk("clr_rd", i % W, i / W);

    // Merged swap requests, write and ignored clear while pending
    swap_req = 1'b1; cyc(); swap_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      swap_req = 1'b1; cyc(); swap_req = 1'b0;
    end
    chk("merge_pend", 32'(swap_pending), 32'd1);
    wr_px(2, 1, 3);
    clear_color = 3'd1; clear_req = 1'b1; cyc(); clear_req = 1'b0;
    chk("pend_clr_ignored", 32'(busy), 32'd0);
    acks = 0;
    for (int k = 0; k < 2; k++) begin
      frame_end = 1'b1; cyc(); frame_end = 1'b0;
      acks += int'(swap_ack);
      cyc();
      acks += int'(swap_ack);
    end
    front_m = 1 - front_m;
    chk("merge_acks", 32'(acks), 32'd1);
    chk("merge_front", 32'(front_sel), 32'(front_m));
    for (int i = 0; i < N; i++) rd_chk("merge_rd", i % W, i / W);

    // Out-of-range coordinates
    wr_px(4, 0, 6);
    wr_px(0, 3, 6);
    swap_now("oor_swap");
    for (int i = 0; i < N; i++) rd_chk("oor_bank", i % W, i / W);
    rd_chk("oor_rd_x", 4, 0);
    rd_chk("oor_rd_y", 0, 3);

    // Reset in the middle of a clear with a deferred swap
    clear_color = 3'd3; clear_req = 1'b1; swap_req = 1'b1;
    cyc();
    clear_req = 1'b0; swap_req = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_pend", 32'(swap_pending), 32'd1);
    repeat (4) cyc();
    resetn = 1'b0; cyc(); resetn = 1'b1;
    front_m = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_front", 32'(front_sel), 32'd0);
    chk("mid_rst_pend", 32'(swap_pending), 32'd0);
    frame_end = 1'b1; cyc(); frame_end = 1'b0;
    chk("mid_fe_front", 32'(front_sel), 32'd0);
    chk("mid_fe_ack", 32'(swap_ack), 32'd0);
    cyc();
    chk("mid_fe_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
